// File: rtl/cac_fault_reconfig_ctrl_if.sv
// Handshake and fault-map bundle between the TSV test logic, the data source
// and the CAC fault-reconfiguration controller.
interface cac_fault_reconfig_ctrl_if #(
    parameter int N_TSV = 9
);
    logic [N_TSV-1:0] fault_in;
    logic             fault_valid;
    logic             fault_ready;
    logic             clear_faults;
    logic             link_valid;
    logic             link_ready;
    logic             coder_en;
    logic [N_TSV-1:0] f_flag;
    logic [3:0]       fault_count;
    logic             over_limit;
    logic             reconfig_busy;
    logic             reconfig_done;

    modport master (
        output fault_in, fault_valid, clear_faults, link_valid,
        input  fault_ready, link_ready, coder_en, f_flag, fault_count,
               over_limit, reconfig_busy, reconfig_done
    );

    modport slave (
        input  fault_in, fault_valid, clear_faults, link_valid,
        output fault_ready, link_ready, coder_en, f_flag, fault_count,
               over_limit, reconfig_busy, reconfig_done
    );
endinterface

// File: rtl/cac_fault_reconfig_ctrl.sv
// Run-time fault-map sequencer for the local-AFNS CAC TSV link: stalls the
// coder, swaps the f_flag vector feeding both FNS adder banks, waits, resumes.
module cac_fault_reconfig_ctrl #(
    parameter int N_TSV      = 9,
    parameter int N_RED      = 4,
    parameter int DRAIN_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                     clock,
    input  logic                     rst_n,
    cac_fault_reconfig_ctrl_if.slave bus
);
    localparam int MAX_CYC = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_APPLY  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_TSV-1:0] pending_q, pending_d;
    logic [N_TSV-1:0] f_flag_q, f_flag_d;
    logic [3:0]       count_q, count_d;
    logic             over_q, over_d;
    logic             done_q, done_d;
    logic [N_TSV-1:0] merged_s;
    logic [3:0]       merged_cnt_s;

    function automatic logic [3:0] popcount(input logic [N_TSV-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < N_TSV; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // State, counter and fault-map registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            pending_q <= {N_TSV{1'b0}};
            f_flag_q  <= {N_TSV{1'b0}};
            count_q   <= 4'd0;
            over_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            f_flag_q  <= f_flag_d;
            count_q   <= count_d;
            over_q    <= over_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; clear has priority over a report in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        f_flag_d     = f_flag_q;
        count_d      = count_q;
        over_d       = over_q;
        done_d       = 1'b0;
        merged_s     = f_flag_q | bus.fault_in;
        merged_cnt_s = popcount(merged_s);
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_faults) begin
                    pending_d = {N_TSV{1'b0}};
                    over_d    = 1'b0;
                    cnt_d     = CW'(DRAIN_CYC - 1);
                    state_d   = ST_DRAIN;
                end else if (bus.fault_valid) begin
                    if (merged_s == f_flag_q) begin
                        state_d = ST_IDLE;
                    end else if (merged_cnt_s > 4'(N_RED)) begin
                        over_d = 1'b1;
                    end else begin
                        pending_d = merged_s;
                        cnt_d     = CW'(DRAIN_CYC - 1);
                        state_d   = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_APPLY: begin
                f_flag_d = pending_q;
                count_d  = popcount(pending_q);
                cnt_d    = CW'(SETTLE_CYC - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The coder only runs in IDLE, so no word sees a changing map.
    assign bus.link_ready    = (state_q == ST_IDLE);
    assign bus.fault_ready   = (state_q == ST_IDLE) & ~bus.clear_faults;
    assign bus.coder_en      = bus.link_valid & bus.link_ready;
    assign bus.reconfig_busy = (state_q != ST_IDLE);
    assign bus.f_flag        = f_flag_q;
    assign bus.fault_count   = count_q;
    assign bus.over_limit    = over_q;
    assign bus.reconfig_done = done_q;
endmodule
